// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector with a run-time reloadable pattern and a saturating match counter.
// The fallback state is derived live from the pattern and recent history, so no failure table is stored.
module mealy_seq_detector #(
  parameter int unsigned          PAT_W       = 4,
  parameter logic [PAT_W-1:0]     PAT_DEFAULT = 4'b1011,
  parameter bit                   OVERLAP     = 1'b1,
  parameter int unsigned          CNT_W       = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         x_in,
  input  logic                         pat_load,
  input  logic [PAT_W-1:0]             pat_value,
  input  logic                         cnt_clr,
  output logic                         y_out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(PAT_W+1)-1:0]   progress
);

  localparam int unsigned PW = $clog2(PAT_W + 1);
  // Progress never exceeds PAT_W-1, so that many history bits plus x_in cover every candidate suffix.
  localparam int unsigned HW = PAT_W - 1;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [HW-1:0]    hist_q, hist_d;
  logic [PW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] win;
  logic [PW-1:0]    fall;
  logic             match;

  assign win   = {hist_q, x_in};
  assign match = en & ~pat_load & (k_q == PW'(PAT_W - 1)) & (x_in == pat_q[0]);

  // Longest suffix of the accepted stream (bounded by k+1 and PAT_W-1) that is a pattern prefix.
  always_comb begin
    fall = '0;
    for (int l = 1; l < int'(PAT_W); l++) begin
      if ((l <= int'(k_q) + 1) &&
          (((win ^ (pat_q >> (int'(PAT_W) - l))) & PAT_W'((1 << l) - 1)) == '0)) begin
        fall = PW'(l);
      end
    end
  end

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    k_d    = k_q;
    cnt_d  = cnt_q;
    if (pat_load) begin
      pat_d  = pat_value;
      hist_d = '0;
      k_d    = '0;
    end else if (en) begin
      hist_d = win[HW-1:0];
      k_d    = (match && !OVERLAP) ? '0 : fall;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q  <= PAT_DEFAULT;
      hist_q <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      k_q    <= k_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y_out     = reset & match;
  assign match_cnt = cnt_q;
  assign progress  = k_q;

endmodule
